uart_cmd_parser: RTL

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_parser.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// UART command frame parser: AA 55 CMD payload [CHK] -> clamped video/scaler config plus an ACK/NAK byte.
// Optional trailing XOR checksum byte is enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_parser #(
  parameter int X_MIN       = 161,
  parameter int X_MAX       = 1920,
  parameter int Y_MIN       = 121,
  parameter int Y_MAX       = 1080,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int LEN_W       = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             uart_rx_flag,
  input  logic [7:0]       uart_rx_data,
  input  logic             tx_busy,
  output logic             tx_req,
  output logic [7:0]       tx_data,
  output logic [LEN_W-1:0] x_pix_len,
  output logic [LEN_W-1:0] y_pix_len,
  output logic             pix_len_update,
  output logic [1:0]       algorithm,
  output logic             vid_format,
  output logic [8:0]       bi_a,
  output logic             cfg_update,
  output logic             frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, HDR2, CMD, PAYLOAD, CHK, COMMIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      pay_q, pay_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [7:0]       resp_q, resp_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [LEN_W-1:0] x_q, x_d, y_q, y_d;
  logic             pix_upd_q, pix_upd_d;
  logic [1:0]       alg_q, alg_d;
  logic             vid_q, vid_d;
  logic [8:0]       bi_a_q, bi_a_d;
  logic             cfg_upd_q, cfg_upd_d;
  logic             err_q, err_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]       chk_q, chk_d;
  logic             chk_ok_q, chk_ok_d;
`endif

  logic active, timeout, commit_ok, nak;

  function automatic logic [LEN_W-1:0] clamp(input logic [15:0] v, input int lo, input int hi);
    logic [15:0] r;
    if (int'(v) < lo)      r = 16'(lo);
    else if (int'(v) > hi) r = 16'(hi);
    else                   r = v;
    return r[LEN_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    pay_d     = pay_q;
    resp_d    = resp_q;
    tx_req_d  = 1'b0;
    tx_data_d = tx_data_q;
    x_d       = x_q;
    y_d       = y_q;
    alg_d     = alg_q;
    vid_d     = vid_q;
    bi_a_d    = bi_a_q;
    pix_upd_d = 1'b0;
    cfg_upd_d = 1'b0;
    err_d     = 1'b0;
    nak       = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    chk_d     = chk_q;
    chk_ok_d  = chk_ok_q;
    commit_ok = chk_ok_q;
`else
    commit_ok = 1'b1;
`endif

    // Inter-byte watchdog only runs while a frame is partially received.
    active   = (state_q == HDR2) || (state_q == CMD) || (state_q == PAYLOAD) || (state_q == CHK);
    to_cnt_d = (uart_rx_flag || !active) ? '0 : to_cnt_q + TO_W'(1);
    timeout  = active && !uart_rx_flag && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    case (state_q)
      IDLE: if (uart_rx_flag && uart_rx_data == 8'hAA) state_d = HDR2;
      HDR2: if (uart_rx_flag) begin
        if (uart_rx_data == 8'h55)      state_d = CMD;
        else if (uart_rx_data != 8'hAA) state_d = IDLE;
      end
      CMD: if (uart_rx_flag) begin
        cmd_d   = uart_rx_data;
        state_d = PAYLOAD;
`ifdef UART_CMD_CHECKSUM_EN
        chk_d   = uart_rx_data;
`endif
        case (uart_rx_data)
          8'h01:        cnt_d = 2'd3;
          8'h02, 8'h03: cnt_d = 2'd0;
          8'h04:        cnt_d = 2'd1;
          default: begin
            state_d = RESP;
            resp_d  = NAK;
            err_d   = 1'b1;
          end
        endcase
      end
      PAYLOAD: if (uart_rx_flag) begin
        pay_d = {pay_q[23:0], uart_rx_data};
`ifdef UART_CMD_CHECKSUM_EN
        chk_d = chk_q ^ uart_rx_data;
`endif
        if (cnt_q == 2'd0) begin
`ifdef UART_CMD_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = COMMIT;
`endif
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      CHK: begin
`ifdef UART_CMD_CHECKSUM_EN
        if (uart_rx_flag) begin
          chk_ok_d = (uart_rx_data == chk_q);
          state_d  = COMMIT;
        end
`else
        state_d = IDLE;
`endif
      end
      COMMIT: begin
        state_d = RESP;
        if (!commit_ok) begin
          nak = 1'b1;
        end else begin
          case (cmd_q)
            8'h01: begin
              x_d       = clamp(pay_q[31:16], X_MIN, X_MAX);
              y_d       = clamp(pay_q[15:0], Y_MIN, Y_MAX);
              pix_upd_d = 1'b1;
            end
            8'h02: begin
              if (pay_q[7:0] > 8'd1) nak = 1'b1;
              else begin
                vid_d     = pay_q[0];
                cfg_upd_d = 1'b1;
              end
            end
            8'h03: begin
              if (pay_q[7:0] > 8'd2) nak = 1'b1;
              else begin
                alg_d     = pay_q[1:0];
                cfg_upd_d = 1'b1;
              end
            end
            default: begin
              bi_a_d    = pay_q[8:0];
              cfg_upd_d = 1'b1;
            end
          endcase
        end
        resp_d = nak ? NAK : ACK;
        err_d  = nak;
      end
      RESP: if (!tx_busy) begin
        tx_req_d  = 1'b1;
        tx_data_d = resp_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      pay_q     <= '0;
      to_cnt_q  <= '0;
      resp_q    <= '0;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      x_q       <= LEN_W'(640);
      y_q       <= LEN_W'(480);
      pix_upd_q <= 1'b0;
      alg_q     <= '0;
      vid_q     <= 1'b0;
      bi_a_q    <= 9'd128;
      cfg_upd_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q     <= '0;
      chk_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      pay_q     <= pay_d;
      to_cnt_q  <= to_cnt_d;
      resp_q    <= resp_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_upd_q <= pix_upd_d;
      alg_q     <= alg_d;
      vid_q     <= vid_d;
      bi_a_q    <= bi_a_d;
      cfg_upd_q <= cfg_upd_d;
      err_q     <= err_d;
`ifdef UART_CMD_CHECKSUM_EN
      chk_q     <= chk_d;
      chk_ok_q  <= chk_ok_d;
`endif
    end
  end

  assign tx_req         = tx_req_q;
  assign tx_data        = tx_data_q;
  assign x_pix_len      = x_q;
  assign y_pix_len      = y_q;
  assign pix_len_update = pix_upd_q;
  assign algorithm      = alg_q;
  assign vid_format     = vid_q;
  assign bi_a           = bi_a_q;
  assign cfg_update     = cfg_upd_q;
  assign frame_err      = err_q;

endmodule
